// File: rtl/regfile_pkg.sv
// Shared definitions for the 32x32 register file write path.
//   RF_ADDR_W / RF_DATA_W / RF_NUM_REGS : register file geometry
//   wctrl_state_t                       : write controller FSM states
package regfile_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } wctrl_state_t;

endpackage

// File: rtl/regfile_write_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index this cycle (held by the parent)
//   grant : one-hot grant to the first requesting index at or after ptr,
//           wrapping modulo NUM_REQ; all-zero when nothing is requested
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] sel;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Write-port controller for the register file.
// After reset it clears every register with zero-writes, then shares the
// single write port among NUM_REQ requesters with round-robin arbitration.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/addr/data   : per-requester write requests (packed slices)
//   req_ready             : one-hot grant, transfer on valid & ready
//   RegWrite/WriteReg/WriteData : registered write port to the file
//   init_busy             : clear sequence in progress
module regfile_write_ctrl
  import regfile_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         WriteReg,
  output logic [DATA_W-1:0]         WriteData,
  output logic                      init_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  // One extra bit keeps the terminal compare clear of wrap-around.
  localparam int CNT_W = ADDR_W + 1;

  wctrl_state_t      state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic              reg_write_reg, reg_write_next;
  logic [ADDR_W-1:0] write_reg_reg, write_reg_next;
  logic [DATA_W-1:0] write_data_reg, write_data_next;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]  grant_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              transfer;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  // Reset overrides any grant so no handshake can complete under reset.
  assign req_ready = (state_reg == RUN && !reset) ? grant : '0;
  assign transfer  = |req_ready;
  assign init_busy = reset || (state_reg == INIT);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

  assign sel_addr = addr_arr[grant_idx];
  assign sel_data = data_arr[grant_idx];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= INIT;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (state_reg == INIT && count_reg == CNT_W'(NUM_REGS - 1)) state_next = RUN;
  end

  // Output / datapath logic: next values of the registered write port.
  always_comb begin
    count_next      = count_reg;
    ptr_next        = ptr_reg;
    reg_write_next  = 1'b0;
    write_reg_next  = write_reg_reg;
    write_data_next = write_data_reg;
    case (state_reg)
      INIT: begin
        reg_write_next  = 1'b1;
        write_reg_next  = count_reg[ADDR_W-1:0];
        write_data_next = '0;
        count_next      = count_reg + 1'b1;
      end
      RUN: begin
        if (transfer) begin
          // Register 0 is hardwired zero: accept the write but never enable it.
          reg_write_next  = (sel_addr != '0);
          write_reg_next  = sel_addr;
          write_data_next = sel_data;
          ptr_next        = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(grant_idx + 1'b1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg      <= '0;
      ptr_reg        <= '0;
      reg_write_reg  <= 1'b0;
      write_reg_reg  <= '0;
      write_data_reg <= '0;
    end else begin
      count_reg      <= count_next;
      ptr_reg        <= ptr_next;
      reg_write_reg  <= reg_write_next;
      write_reg_reg  <= write_reg_next;
      write_data_reg <= write_data_next;
    end
  end

  assign RegWrite  = reg_write_reg;
  assign WriteReg  = write_reg_reg;
  assign WriteData = write_data_reg;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: init sweep, single write,
// table-driven round-robin vectors, register-0 policy and mid-run resets.
module tb_regfile_write_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        init_busy;

  int checks = 0;
  int errors = 0;

  regfile_write_ctrl #(
    .NUM_REQ  (3),
    .ADDR_W   (5),
    .DATA_W   (32),
    .NUM_REGS (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  exp_ready;
    logic        exp_rw;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [31:0] dval(input int i);
    return 32'hA5A5_0000 | 32'(i + 1);
  endfunction

  // Table requesters use addr i+1 and data dval(i); idx names the requester
  // whose values should appear on the write port after the edge.
  function automatic vec_t mk(input logic [2:0] v, input logic [2:0] r,
                              input logic rw, input int idx);
    vec_t t;
    t.valid     = v;
    t.exp_ready = r;
    t.exp_rw    = rw;
    t.exp_wreg  = 5'(idx + 1);
    t.exp_wdata = dval(idx);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Releases reset and checks the full 32-write clear sequence.
  task automatic init_sweep();
    reset     = 1'b0;
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("init_rw", 64'(RegWrite), 64'(1));
      chk("init_wreg", 64'(WriteReg), 64'(k));
      chk("init_wdata", 64'(WriteData), 64'(0));
      chk("init_busy", 64'(init_busy), (k == 31) ? 64'(0) : 64'(1));
      if (k < 31) chk("init_ready", 64'(req_ready), 64'(0));
      else req_valid = 3'b000;
    end
    $display("init sweep done: 32 clear writes");
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 3'b000;
    req_addr  = '0;
    req_data  = '0;

    vecs[0]  = mk(3'b111, 3'b100, 1'b1, 2);
    vecs[1]  = mk(3'b111, 3'b001, 1'b1, 0);
    vecs[2]  = mk(3'b111, 3'b010, 1'b1, 1);
    vecs[3]  = mk(3'b111, 3'b100, 1'b1, 2);
    vecs[4]  = mk(3'b111, 3'b001, 1'b1, 0);
    vecs[5]  = mk(3'b111, 3'b010, 1'b1, 1);
    vecs[6]  = mk(3'b111, 3'b100, 1'b1, 2);
    vecs[7]  = mk(3'b101, 3'b001, 1'b1, 0);
    vecs[8]  = mk(3'b101, 3'b100, 1'b1, 2);
    vecs[9]  = mk(3'b101, 3'b001, 1'b1, 0);
    vecs[10] = mk(3'b101, 3'b100, 1'b1, 2);
    vecs[11] = mk(3'b000, 3'b000, 1'b0, 2);
    vecs[12] = mk(3'b110, 3'b010, 1'b1, 1);
    vecs[13] = mk(3'b011, 3'b001, 1'b1, 0);
    vecs[14] = mk(3'b001, 3'b001, 1'b1, 0);

    // Reset state, with requests present: reset must win.
    tick();
    req_valid = 3'b111;
    tick();
    chk("rst_rw", 64'(RegWrite), 64'(0));
    chk("rst_wreg", 64'(WriteReg), 64'(0));
    chk("rst_wdata", 64'(WriteData), 64'(0));
    chk("rst_busy", 64'(init_busy), 64'(1));
    chk("rst_ready", 64'(req_ready), 64'(0));

    init_sweep();

    // Single write from requester 1.
    req_addr  = {5'd0, 5'd5, 5'd0};
    req_data  = {32'd0, 32'hDEADBEEF, 32'd0};
    req_valid = 3'b010;
    #1;
    chk("single_ready", 64'(req_ready), 64'(3'b010));
    tick();
    chk("single_rw", 64'(RegWrite), 64'(1));
    chk("single_wreg", 64'(WriteReg), 64'(5));
    chk("single_wdata", 64'(WriteData), 64'h0000_0000_DEAD_BEEF);
    req_valid = 3'b000;
    #1;
    chk("idle_ready", 64'(req_ready), 64'(0));
    tick();
    chk("idle_rw", 64'(RegWrite), 64'(0));
    chk("idle_wreg_hold", 64'(WriteReg), 64'(5));
    chk("idle_wdata_hold", 64'(WriteData), 64'h0000_0000_DEAD_BEEF);
    $display("single write: addr 5 data deadbeef");

    // Round-robin table; pointer starts at 2 after the single write.
    req_addr = {5'd3, 5'd2, 5'd1};
    req_data = {dval(2), dval(1), dval(0)};
    for (int i = 0; i < 15; i++) begin
      req_valid = vecs[i].valid;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      tick();
      chk($sformatf("v%0d_rw", i), 64'(RegWrite), 64'(vecs[i].exp_rw));
      chk($sformatf("v%0d_wreg", i), 64'(WriteReg), 64'(vecs[i].exp_wreg));
      chk($sformatf("v%0d_wdata", i), 64'(WriteData), 64'(vecs[i].exp_wdata));
      $display("vec %0d valid=%b ready=%b rw=%0d wreg=%0d wdata=%h",
               i, vecs[i].valid, req_ready, RegWrite, WriteReg, WriteData);
    end

    // Register 0: accepted, pointer advances (ptr is 1 here), no enable.
    req_addr  = {5'd3, 5'd2, 5'd0};
    req_data  = {dval(2), dval(1), 32'h0000_1234};
    req_valid = 3'b001;
    #1;
    chk("r0_ready", 64'(req_ready), 64'(3'b001));
    tick();
    chk("r0_rw", 64'(RegWrite), 64'(0));
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {dval(2), dval(1), dval(0)};
    req_valid = 3'b111;
    #1;
    chk("r0_ptr_adv", 64'(req_ready), 64'(3'b010));
    tick();
    chk("r0_next_rw", 64'(RegWrite), 64'(1));
    chk("r0_next_wreg", 64'(WriteReg), 64'(2));
    $display("reg0 write: accepted without enable");

    // Reset during back-to-back RUN traffic.
    tick();
    chk("b2b_wreg", 64'(WriteReg), 64'(3));
    reset = 1'b1;
    #1;
    chk("run_rst_ready", 64'(req_ready), 64'(0));
    chk("run_rst_busy", 64'(init_busy), 64'(1));
    tick();
    chk("run_rst_rw", 64'(RegWrite), 64'(0));
    chk("run_rst_wreg", 64'(WriteReg), 64'(0));
    chk("run_rst_wdata", 64'(WriteData), 64'(0));
    init_sweep();
    req_valid = 3'b111;
    #1;
    chk("ptr_after_rst", 64'(req_ready), 64'(3'b001));
    req_valid = 3'b000;
    $display("reset during run: clear restarted");

    // Reset at init write 10.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      tick();
      chk("part_wreg", 64'(WriteReg), 64'(k));
    end
    reset = 1'b1;
    #1;
    tick();
    chk("init_rst_rw", 64'(RegWrite), 64'(0));
    chk("init_rst_wreg", 64'(WriteReg), 64'(0));
    chk("init_rst_busy", 64'(init_busy), 64'(1));
    init_sweep();
    $display("reset during init: clear restarted");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
